cadd_pipe: RTL and testbench
============================

Name: cadd_pipe

Overview:
Pipelined, multi-channel complex adder/subtractor with valid/ready handshake, for the radix-2/radix-4 FFT butterflies in the fft datapath. Per transaction it computes A±B or A±jB on NUM_CH independent complex lanes. Optional scale-by-½ with rounding handles stage-wise overflow control. It reports per-lane and sticky overflow.

Parameters:
DATA_WIDTH, 16, bits per real and per imaginary component (signed two's complement)
NUM_CH, 1, number of parallel complex lanes; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input this cycle
op  input  2  00 A+B, 01 A-B, 10 A+jB, 11 A-jB; sampled with beat
scale  input  1  1 = result halved with rounding; sampled with beat
a_real, a_imag  input  NUM_CH*DATA_WIDTH  operand A lanes
b_real, b_imag  input  NUM_CH*DATA_WIDTH  operand B lanes
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output
y_real, y_imag  output  NUM_CH*DATA_WIDTH  result lanes
ovf  output  NUM_CH  per-lane overflow for current output beat
ovf_sticky  output  1  OR of all ovf since reset or last clear
ovf_clr  input  1  synchronous clear of ovf_sticky

Behaviour:
- One clock domain; asynchronous active-low reset. On reset: out_valid=0, y_real=y_imag=0, ovf=0, ovf_sticky=0, both pipeline stages empty. Reset mid-operation discards in-flight beats; no output follows deassertion until new input is accepted.
- Input accepted when in_valid && in_ready; output transferred when out_valid && out_ready.
- Stage 1 registers full-precision sums, DATA_WIDTH+1 bits per component, sign-extended operands:
  - op 00: re=Ar+Br, im=Ai+Bi
  - op 01: re=Ar-Br, im=Ai-Bi
  - op 10: re=Ar-Bi, im=Ai+Br
  - op 11: re=Ar+Bi, im=Ai-Br
- Stage 2 registers the narrowed result, ovf, and out_valid.
  - scale=0: keep the low DATA_WIDTH bits; overflow if the value lies outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - scale=1: compute (s+1)>>>1 in DATA_WIDTH+2 bits (round half up), then apply the same range check.
  - Add-type ops with scale=1 never overflow. Sub-type ops can: max-positive minus max-negative gives +2^(DATA_WIDTH-1), which overflows.
- Latency: exactly 2 cycles from accept to out_valid when not stalled. Throughput: 1 beat/cycle.
- Flow control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational)
  - Stalled stages hold data, op/scale state and ovf stable. No beat is dropped, duplicated or reordered.
  - out_valid, once asserted, stays high until the output transfers.
- ovf[k] = lane k real or imaginary overflowed; meaningful only while out_valid.
- ovf_sticky sets on any output transfer with |ovf. If ovf_clr and a setting event coincide, set wins.
- Lanes are fully independent; a lane's overflow never affects other lanes.

Optional Feature:
CADD_SAT_EN:
- Defined: an overflowing component saturates to 2^(DATA_WIDTH-1)-1 (positive) or -2^(DATA_WIDTH-1) (negative). ovf and ovf_sticky still report the overflow.
- Undefined: overflowing components wrap (low DATA_WIDTH bits kept).
- Latency and handshake are identical in both builds.

Test Plan:
- DATA_WIDTH=16, NUM_CH=1, op=00, scale=0, A=(100,-200), B=(50,25) -> 2 cycles later y=(150,-175), ovf=0.
- op=10, A=(10,20), B=(3,4) -> y=(6,23). op=11 with same operands -> y=(14,17).
- op=00, scale=0, A=(32767,0), B=(1,0) -> y_real=-32768 (wrap) or 32767 with CADD_SAT_EN; ovf=1, ovf_sticky=1. Then ovf_clr for 1 cycle -> ovf_sticky=0.
- scale=1:
  - op=00, A=(32767,-32768), B=(32767,-32768) -> y=(32767,-32768), ovf=0.
  - op=01, A=(32767,0), B=(-32768,0) -> ovf=1, y_real=-32768 (wrap) or 32767 (sat).
- NUM_CH=4, 6 back-to-back beats, out_ready held low for 3 cycles mid-stream -> in_ready drops once both stages are full. All 6 results arrive in order, per-lane correct, and outputs stay stable while stalled.
- Assert rst_n low with 2 beats in flight -> out_valid=0, y=0 immediately (asynchronous). No stale output after release.

Source files
------------

// File: rtl/cadd_pipe.sv
// cadd_pipe: two-stage pipelined multi-lane complex adder (A+B, A-B, A+jB, A-jB) with optional
// round-half-up halving and per-lane/sticky overflow. Define CADD_SAT_EN to saturate instead of wrap.
module cadd_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   op,
  input  logic                         scale,
  input  logic [NUM_CH*DATA_WIDTH-1:0] a_real,
  input  logic [NUM_CH*DATA_WIDTH-1:0] a_imag,
  input  logic [NUM_CH*DATA_WIDTH-1:0] b_real,
  input  logic [NUM_CH*DATA_WIDTH-1:0] b_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] y_real,
  output logic [NUM_CH*DATA_WIDTH-1:0] y_imag,
  output logic [NUM_CH-1:0]            ovf,
  output logic                         ovf_sticky,
  input  logic                         ovf_clr
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 1;

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_adv;
  logic                 s2_adv;
  logic                 s1_scale;
  logic [NUM_CH*SW-1:0] sum_re;
  logic [NUM_CH*SW-1:0] sum_im;
  logic [NUM_CH*SW-1:0] s1_re;
  logic [NUM_CH*SW-1:0] s1_im;
  logic [NUM_CH*W-1:0]  nar_re;
  logic [NUM_CH*W-1:0]  nar_im;
  logic [NUM_CH-1:0]    nar_ovf;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Returns {overflow, value}; the extra top bit keeps the rounding increment from wrapping.
  function automatic logic [W:0] narrow(input logic [SW-1:0] s, input logic halve);
    logic signed [W+1:0] ext;
    logic signed [W+1:0] inc;
    logic signed [W+1:0] r;
    logic                lost;
    logic [W-1:0]        v;
    ext  = {s[SW-1], s};
    inc  = ext + {{(W+1){1'b0}}, 1'b1};
    r    = halve ? (inc >>> 1) : ext;
    lost = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
    v    = r[W-1:0];
`ifdef CADD_SAT_EN
    if (lost) v = r[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {lost, v};
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [SW-1:0] ar;
    logic [SW-1:0] ai;
    logic [SW-1:0] br;
    logic [SW-1:0] bi;
    logic [SW-1:0] re;
    logic [SW-1:0] im;
    logic [W:0]    res_re;
    logic [W:0]    res_im;

    assign ar = {a_real[k*W+W-1], a_real[k*W +: W]};
    assign ai = {a_imag[k*W+W-1], a_imag[k*W +: W]};
    assign br = {b_real[k*W+W-1], b_real[k*W +: W]};
    assign bi = {b_imag[k*W+W-1], b_imag[k*W +: W]};

    // Multiplying B by +j/-j swaps its components, so the jB ops cross real and imaginary.
    always_comb begin
      re = ar + br;
      im = ai + bi;
      case (op)
        2'b01: begin re = ar - br; im = ai - bi; end
        2'b10: begin re = ar - bi; im = ai + br; end
        2'b11: begin re = ar + bi; im = ai - br; end
        default: ;
      endcase
    end

    assign sum_re[k*SW +: SW] = re;
    assign sum_im[k*SW +: SW] = im;

    assign res_re            = narrow(s1_re[k*SW +: SW], s1_scale);
    assign res_im            = narrow(s1_im[k*SW +: SW], s1_scale);
    assign nar_re[k*W +: W]  = res_re[W-1:0];
    assign nar_im[k*W +: W]  = res_im[W-1:0];
    assign nar_ovf[k]        = res_re[W] | res_im[W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_scale <= scale;
        s1_re    <= sum_re;
        s1_im    <= sum_im;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y_real   <= '0;
      y_imag   <= '0;
      ovf      <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y_real <= nar_re;
        y_imag <= nar_im;
        ovf    <= nar_ovf;
      end
    end
  end

  // A setting transfer beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (s2_valid && out_ready && (|ovf)) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cadd_pipe.sv
// tb_cadd_pipe: self-checking bench for cadd_pipe (4 lanes) against an integer-arithmetic
// reference model with a queue of expected beats.
module tb_cadd_pipe;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct {
    logic [N*W-1:0] yr;
    logic [N*W-1:0] yi;
    logic [N-1:0]   ov;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     op;
  logic           scale;
  logic [N*W-1:0] a_real;
  logic [N*W-1:0] a_imag;
  logic [N*W-1:0] b_real;
  logic [N*W-1:0] b_imag;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] y_real;
  logic [N*W-1:0] y_imag;
  logic [N-1:0]   ovf;
  logic           ovf_sticky;
  logic           ovf_clr;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  bit   sticky_m = 1'b0;
  bit   last_in_fire;
  bit   last_in_ready;

  always #5 clk = ~clk;

  cadd_pipe #(.DATA_WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .scale(scale), .a_real(a_real), .a_imag(a_imag),
    .b_real(b_real), .b_imag(b_imag), .out_valid(out_valid), .out_ready(out_ready),
    .y_real(y_real), .y_imag(y_imag), .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One component: halve with round half up when asked, then range-check and wrap or saturate.
  function automatic void model_comp(input int s, input bit sc, output logic [W-1:0] v, output bit o);
    int r;
    r = sc ? ((s + 1) >>> 1) : s;
    o = (r > 32767) || (r < -32768);
    v = r[W-1:0];
`ifdef CADD_SAT_EN
    if (o) v = (r > 0) ? 16'h7fff : 16'h8000;
`endif
  endfunction

  function automatic exp_t model_beat(input logic [1:0] o, input bit sc,
                                      input logic [N*W-1:0] ar, input logic [N*W-1:0] ai,
                                      input logic [N*W-1:0] br, input logic [N*W-1:0] bi);
    exp_t e;
    int xr, xi, zr, zi, re, im;
    logic [W-1:0] v;
    bit of1, of2;
    for (int k = 0; k < N; k++) begin
      xr = int'(signed'(ar[k*W +: W]));
      xi = int'(signed'(ai[k*W +: W]));
      zr = int'(signed'(br[k*W +: W]));
      zi = int'(signed'(bi[k*W +: W]));
      case (o)
        2'b00:   begin re = xr + zr; im = xi + zi; end
        2'b01:   begin re = xr - zr; im = xi - zi; end
        2'b10:   begin re = xr - zi; im = xi + zr; end
        default: begin re = xr + zi; im = xi - zr; end
      endcase
      model_comp(re, sc, v, of1);
      e.yr[k*W +: W] = v;
      model_comp(im, sc, v, of2);
      e.yi[k*W +: W] = v;
      e.ov[k] = of1 | of2;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return 16'h7fff;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [N*W-1:0] rnd_vec();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = rnd_val();
    return r;
  endfunction

  function automatic logic [N*W-1:0] lane0(input int v);
    logic [N*W-1:0] r;
    r = rnd_vec();
    r[W-1:0] = 16'(v);
    return r;
  endfunction

  task automatic check_output();
    int cnt;
    cnt = q.size();
    check("in_ready", 64'(in_ready), 64'((cnt < 2) || out_ready));
    check("ovf_sticky", 64'(ovf_sticky), 64'(sticky_m));
    if (cnt == 0) begin
      check("idle_out_valid", 64'(out_valid), 64'(1'b0));
    end else if (out_valid) begin
      check("y_real", 64'(y_real), 64'(q[0].yr));
      check("y_imag", 64'(y_imag), 64'(q[0].yi));
      check("ovf", 64'(ovf), 64'(q[0].ov));
    end
  endtask

  // Called at a falling edge; drives one cycle, checks, and returns at the next falling edge.
  task automatic apply_stimulus(input bit iv, input logic [1:0] o, input bit sc,
                                input logic [N*W-1:0] ar, input logic [N*W-1:0] ai,
                                input logic [N*W-1:0] br, input logic [N*W-1:0] bi,
                                input bit ordy, input bit clr);
    bit out_fire, ovf_fire;
    exp_t d;
    in_valid = iv; op = o; scale = sc;
    a_real = ar; a_imag = ai; b_real = br; b_imag = bi;
    out_ready = ordy; ovf_clr = clr;
    #1;
    check_output();
    last_in_ready = in_ready;
    last_in_fire  = in_valid && in_ready;
    out_fire      = out_valid && out_ready;
    ovf_fire      = 1'b0;
    if (out_fire && q.size() > 0) begin
      ovf_fire = |q[0].ov;
      d = q.pop_front();
    end
    if (last_in_fire) q.push_back(model_beat(o, sc, ar, ai, br, bi));
    @(posedge clk);
    if (ovf_fire) sticky_m = 1'b1;
    else if (clr) sticky_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_cycle(input bit ordy, input bit clr);
    apply_stimulus(1'b0, 2'b00, 1'b0, '0, '0, '0, '0, ordy, clr);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle_cycle(1'b1, 1'b0);
    check("drain", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent;
    bit saw_low;
    bit ordy;
    in_valid = 0; op = 0; scale = 0; out_ready = 0; ovf_clr = 0;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_y_real", 64'(y_real), 64'(0));
    check("rst_y_imag", 64'(y_imag), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_sticky", 64'(ovf_sticky), 64'(1'b0));
    check("rst_in_ready", 64'(in_ready), 64'(1'b1));
    rst_n = 1'b1;
    idle_cycle(1'b1, 1'b0);

    $display("[TB] basic add and two-cycle latency");
    apply_stimulus(1'b1, 2'b00, 1'b0, lane0(100), lane0(-200), lane0(50), lane0(25), 1'b1, 1'b0);
    check("lat_cycle1", 64'(out_valid), 64'(1'b0));
    idle_cycle(1'b1, 1'b0);
    check("lat_cycle2", 64'(out_valid), 64'(1'b1));
    check("t1_re", 64'(y_real[W-1:0]), 64'(16'd150));
    check("t1_im", 64'(y_imag[W-1:0]), 64'(16'hff51));
    drain();

    $display("[TB] rotated ops");
    apply_stimulus(1'b1, 2'b10, 1'b0, lane0(10), lane0(20), lane0(3), lane0(4), 1'b1, 1'b0);
    apply_stimulus(1'b1, 2'b11, 1'b0, lane0(10), lane0(20), lane0(3), lane0(4), 1'b1, 1'b0);
    drain();

    $display("[TB] overflow and sticky clear");
    apply_stimulus(1'b1, 2'b00, 1'b0, lane0(32767), lane0(0), lane0(1), lane0(0), 1'b1, 1'b0);
    drain();
    check("sticky_set", 64'(ovf_sticky), 64'(1'b1));
    idle_cycle(1'b1, 1'b1);
    check("sticky_clr", 64'(ovf_sticky), 64'(1'b0));

    $display("[TB] scaled extremes");
    apply_stimulus(1'b1, 2'b00, 1'b1, lane0(32767), lane0(-32768), lane0(32767), lane0(-32768), 1'b1, 1'b0);
    apply_stimulus(1'b1, 2'b01, 1'b1, lane0(32767), lane0(0), lane0(-32768), lane0(0), 1'b1, 1'b0);
    drain();

    $display("[TB] six beats with mid-stream stall");
    sent = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 40 && (sent < 6 || q.size() > 0); c++) begin
      ordy = !(c >= 2 && c <= 4);
      apply_stimulus(sent < 6, 2'($urandom), 1'($urandom), rnd_vec(), rnd_vec(), rnd_vec(),
                     rnd_vec(), ordy, 1'b0);
      if (last_in_fire) sent++;
      if (sent < 6 && !last_in_ready) saw_low = 1'b1;
    end
    check("stall_sent", 64'(sent), 64'(6));
    check("stall_drained", 64'(q.size()), 64'(0));
    check("in_ready_dropped", 64'(saw_low), 64'(1'b1));

    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++) begin
      apply_stimulus(($urandom % 4) != 0, 2'($urandom), 1'($urandom), rnd_vec(), rnd_vec(),
                     rnd_vec(), rnd_vec(), ($urandom % 4) != 0, ($urandom % 16) == 0);
    end
    drain();

    $display("[TB] reset with beats in flight");
    apply_stimulus(1'b1, 2'b01, 1'b0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b10, 1'b0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, 1'b0);
    check("inflight_valid", 64'(out_valid), 64'(1'b1));
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(1'b0));
    check("arst_y_real", 64'(y_real), 64'(0));
    check("arst_y_imag", 64'(y_imag), 64'(0));
    check("arst_ovf", 64'(ovf), 64'(0));
    check("arst_sticky", 64'(ovf_sticky), 64'(1'b0));
    q.delete();
    sticky_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle_cycle(1'b1, 1'b0);
    apply_stimulus(1'b1, 2'b00, 1'b0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
